magnitude_pipe: RTL
===================

Name: magnitude_pipe

Overview:
Parametrised successor to the single-stage gradient-magnitude block in the Sobel datapath. Accepts signed gx/gy gradient pairs and takes their absolute values. Combines them per a runtime-selected norm (L1, L-inf, approximate L2), then shifts and saturates to the output pixel width. Three-stage elastic pipeline with valid/ready on both sides, sitting between the Sobel convolution and the output/threshold stage.

Parameters:
WIDTH_P, 11, width of signed two's-complement gx_i/gy_i.
OUT_WIDTH_P, 8, width of unsigned mag_o.
SHIFT_P, 0, right shift applied to the combined result before saturation (0..WIDTH_P).

Ports:
clk_i  in  1  clock; all state on rising edge.
rstn_i  in  1  reset; asynchronous, active-low.
valid_i  in  1  upstream beat valid.
ready_o  out  1  block can accept a beat this cycle.
gx_i  in  WIDTH_P  signed horizontal gradient.
gy_i  in  WIDTH_P  signed vertical gradient.
mode_i  in  2  norm select, sampled with the beat: 0 = L1, 1 = L-inf, 2 = approx L2, 3 = reserved (behaves as L1).
valid_o  out  1  output beat valid.
ready_i  in  1  downstream accepts.
mag_o  out  OUT_WIDTH_P  saturated magnitude.

Behaviour:
- Reset (rstn_i low, any time, asynchronous): all stage valid bits clear, so valid_o=0 and ready_o=1 (ready_o is combinational from stage valids and ready_i). mag_o=0. Data registers clear. Beats in flight are discarded; no beat is emitted after reset.
- Handshake: a beat transfers on valid_i&&ready_o at input and valid_o&&ready_i at output.
  - Each stage loads when it is empty or its own content advances that cycle; stage_k advances = valid_k && (stage_k+1 empty or advancing).
  - ready_o = ~valid_s1 || s1 advances.
  - Full throughput: 1 beat/cycle when ready_i stays high. Latency: exactly 3 cycles from accept to valid_o.
  - When valid_o is high and ready_i is low, mag_o and valid_o hold stable. No beat is dropped or duplicated. When all 3 stages are full, ready_o=0.
  - If valid_i is deasserted mid-stream, bubbles propagate.
- S1 (abs): |gx|, |gy| as WIDTH_P-bit unsigned. The most negative input -2^(WIDTH_P-1) maps to 2^(WIDTH_P-1) with no overflow. mode is registered alongside.
- S2 (combine): mx = max(|gx|,|gy|), mn = min. WIDTH_P+1-bit result:
  - L1: mx+mn.
  - L-inf: mx.
  - Approx L2: mx + (mn>>2) + (mn>>3), truncating shifts.
- S3 (scale/saturate): r = result >> SHIFT_P. If r > 2^OUT_WIDTH_P - 1, mag_o = all ones; else mag_o = r.
- mode_i travels with its beat, so a mode change between consecutive beats takes effect exactly on the next beat.

Optional Feature:
Macro MAGNITUDE_PIPE_THRESH_EN.
- Defined: adds input thresh_i [OUT_WIDTH_P] and output edge_o [1].
  - thresh_i is sampled with the beat at S1 and carried through the pipeline.
  - edge_o = (saturated mag >= thresh), registered in S3, valid and held with valid_o. It resets to 0.
- Undefined: neither port exists, no threshold logic is built, and behaviour is otherwise identical.

Decomposition:
- Shared package magnitude_pkg: mode_e enum (MAG_L1, MAG_LINF, MAG_L2APPROX, MAG_RSVD) and a function sat_trunc for saturating truncation.
- One natural sub-module: pipe_stage, a one-entry elastic register with valid/ready and a data width parameter, instantiated three times. Combinational logic sits between instances.

Test Plan:
- Reset: hold rstn_i low with valid_i=1 → valid_o=0, ready_o=1, mag_o=0. Assert reset mid-stream with 3 beats in flight → no output after release.
- L1 (defaults): gx=-300, gy=100 → 400 saturates to 255. gx=30, gy=-40 → 70, appearing on the 3rd cycle after accept.
- L-inf: gx=-1024, gy=5 → 1024 saturates to 255. With SHIFT_P=3 → 128.
- Approx L2: gx=40, gy=30 → 40+7+3 = 50. gx=-12, gy=0 → 12.
- Back-pressure: stream 10 beats with ready_i toggling 1,0,0,1 pseudo-randomly → outputs appear in order with no loss or duplication. ready_o drops only when all 3 stages are full. mag_o is stable while stalled.
- Mode switch plus threshold (macro defined): alternate modes on back-to-back beats gx=40, gy=30 → 70, 40, 50. With thresh=50 → edge_o = 1, 0, 1.

Source files
------------

// File: rtl/magnitude_pkg.sv
// Shared types and helpers for the gradient-magnitude pipeline.
// Norm selection encoding and saturating truncation.
package magnitude_pkg;

   typedef enum logic [1:0] {
      MAG_L1       = 2'd0,
      MAG_LINF     = 2'd1,
      MAG_L2APPROX = 2'd2,
      MAG_RSVD     = 2'd3
   } mode_e;

   // Clamp val_i to the largest value representable in width_i unsigned bits.
   function automatic logic [31:0] sat_trunc(input logic [31:0] val_i, input int unsigned width_i);
      logic [31:0] max_v;
      max_v = (32'd1 << width_i) - 32'd1;
      if (val_i > max_v) begin
         sat_trunc = max_v;
      end else begin
         sat_trunc = val_i;
      end
   endfunction

endpackage

// File: rtl/magnitude_pipe_stage.sv
// pipe_stage: one-entry elastic register with valid/ready handshake.
// Loads when empty or when its current content leaves in the same cycle.
module pipe_stage #(
   parameter int unsigned DATA_W_P = 8
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [DATA_W_P-1:0] data_i,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [DATA_W_P-1:0] data_o
);

   logic                valid_q, valid_d;
   logic [DATA_W_P-1:0] data_q, data_d;

   // Free slot this cycle: empty, or current beat is taken downstream.
   always_comb begin
      ready_o = ~valid_q | ready_i;
   end

   // Next-state for occupancy and payload.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (ready_o) begin
         valid_d = valid_i;
         if (valid_i) begin
            data_d = data_i;
         end else begin
            data_d = data_q;
         end
      end else begin
         valid_d = valid_q;
         data_d  = data_q;
      end
   end

   // Stage register.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/magnitude_pipe.sv
// magnitude_pipe: abs -> norm combine -> shift/saturate, three elastic stages.
// Optional threshold output enabled by defining MAGNITUDE_PIPE_THRESH_EN.
module magnitude_pipe
   import magnitude_pkg::*;
#(
   parameter int unsigned WIDTH_P     = 11,
   parameter int unsigned OUT_WIDTH_P = 8,
   parameter int unsigned SHIFT_P     = 0
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic signed [WIDTH_P-1:0]  gx_i,
   input  logic signed [WIDTH_P-1:0]  gy_i,
   input  logic [1:0]                 mode_i,
`ifdef MAGNITUDE_PIPE_THRESH_EN
   input  logic [OUT_WIDTH_P-1:0]     thresh_i,
   output logic                       edge_o,
`endif
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [OUT_WIDTH_P-1:0]     mag_o
);

   localparam int unsigned SUM_W = WIDTH_P + 1;
`ifdef MAGNITUDE_PIPE_THRESH_EN
   localparam int unsigned S1_W = 2 * WIDTH_P + 2 + OUT_WIDTH_P;
   localparam int unsigned S2_W = SUM_W + OUT_WIDTH_P;
   localparam int unsigned S3_W = OUT_WIDTH_P + 1;
`else
   localparam int unsigned S1_W = 2 * WIDTH_P + 2;
   localparam int unsigned S2_W = SUM_W;
   localparam int unsigned S3_W = OUT_WIDTH_P;
`endif

   logic [WIDTH_P-1:0]     abs_x_s, abs_y_s;
   logic [WIDTH_P-1:0]     s1_ax_s, s1_ay_s, mx_s, mn_s;
   logic [1:0]             s1_mode_s;
   logic [SUM_W-1:0]       comb_s, s2_sum_s, shifted_s;
   logic [OUT_WIDTH_P-1:0] sat_s;
   logic [S1_W-1:0]        s1_in_s, s1_out_s;
   logic [S2_W-1:0]        s2_in_s, s2_out_s;
   logic [S3_W-1:0]        s3_in_s, s3_out_s;
   logic                   s1_valid_s, s2_valid_s, s2_ready_s, s3_ready_s;

   // Two's-complement negate; the most negative input lands on 2^(WIDTH_P-1).
   always_comb begin
      if (gx_i[WIDTH_P-1]) begin
         abs_x_s = WIDTH_P'(-gx_i);
      end else begin
         abs_x_s = gx_i;
      end
      if (gy_i[WIDTH_P-1]) begin
         abs_y_s = WIDTH_P'(-gy_i);
      end else begin
         abs_y_s = gy_i;
      end
   end

`ifdef MAGNITUDE_PIPE_THRESH_EN
   logic [OUT_WIDTH_P-1:0] s1_th_s, s2_th_s;
   logic                   edge_s;
   assign s1_in_s = {abs_x_s, abs_y_s, mode_i, thresh_i};
   assign {s1_ax_s, s1_ay_s, s1_mode_s, s1_th_s} = s1_out_s;
   assign s2_in_s = {comb_s, s1_th_s};
   assign {s2_sum_s, s2_th_s} = s2_out_s;
   assign edge_s  = (sat_s >= s2_th_s);
   assign s3_in_s = {sat_s, edge_s};
   assign {mag_o, edge_o} = s3_out_s;
`else
   assign s1_in_s = {abs_x_s, abs_y_s, mode_i};
   assign {s1_ax_s, s1_ay_s, s1_mode_s} = s1_out_s;
   assign s2_in_s  = comb_s;
   assign s2_sum_s = s2_out_s;
   assign s3_in_s  = sat_s;
   assign mag_o    = s3_out_s;
`endif

   pipe_stage #(.DATA_W_P(S1_W)) u_s1 (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .valid_i(valid_i), .ready_o(ready_o), .data_i(s1_in_s),
      .valid_o(s1_valid_s), .ready_i(s2_ready_s), .data_o(s1_out_s)
   );

   // Order the pair so the combine only needs max/min.
   always_comb begin
      if (s1_ax_s >= s1_ay_s) begin
         mx_s = s1_ax_s;
         mn_s = s1_ay_s;
      end else begin
         mx_s = s1_ay_s;
         mn_s = s1_ax_s;
      end
   end

   // Norm combine; the reserved encoding falls back to L1.
   always_comb begin
      comb_s = SUM_W'(mx_s) + SUM_W'(mn_s);
      case (mode_e'(s1_mode_s))
         MAG_L1:       comb_s = SUM_W'(mx_s) + SUM_W'(mn_s);
         MAG_LINF:     comb_s = SUM_W'(mx_s);
         MAG_L2APPROX: comb_s = SUM_W'(mx_s) + SUM_W'(mn_s >> 2'd2) + SUM_W'(mn_s >> 2'd3);
         default:      comb_s = SUM_W'(mx_s) + SUM_W'(mn_s);
      endcase
   end

   pipe_stage #(.DATA_W_P(S2_W)) u_s2 (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .valid_i(s1_valid_s), .ready_o(s2_ready_s), .data_i(s2_in_s),
      .valid_o(s2_valid_s), .ready_i(s3_ready_s), .data_o(s2_out_s)
   );

   // Scale down, then clamp to the output pixel range.
   always_comb begin
      shifted_s = s2_sum_s >> SHIFT_P;
      sat_s     = OUT_WIDTH_P'(sat_trunc(32'(shifted_s), OUT_WIDTH_P));
   end

   pipe_stage #(.DATA_W_P(S3_W)) u_s3 (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .valid_i(s2_valid_s), .ready_o(s3_ready_s), .data_i(s3_in_s),
      .valid_o(valid_o), .ready_i(ready_i), .data_o(s3_out_s)
   );

endmodule
